// File: rtl/report_frame_streamer.sv
// Streams report BRAM records to the UART transmitter, one ASCII-framed line per record.
// Each frame is OPEN, the fields separated by SEP, then EOL; fields are sent MSB byte first.
module report_frame_streamer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned NUM_FIELDS  = 3,
  parameter int unsigned FIELD_BYTES = 1,
  parameter logic [7:0]  OPEN_BYTE   = 8'h5B,
  parameter logic [7:0]  SEP_BYTE    = 8'h5C,
  parameter logic [7:0]  EOL_BYTE    = 8'h0A
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                stop,
  input  logic                                continuous,
  input  logic [ADDR_W-1:0]                   last_addr,
  output logic                                mem_en,
  output logic [ADDR_W-1:0]                   mem_addr,
  input  logic [NUM_FIELDS*FIELD_BYTES*8-1:0] mem_rdata,
  output logic                                tx_start,
  output logic [7:0]                          tx_data,
  input  logic                                tx_busy,
  output logic                                busy,
  output logic                                done,
  output logic [15:0]                         frame_count
);

  localparam int unsigned REC_W     = NUM_FIELDS * FIELD_BYTES * 8;
  localparam int unsigned FRAME_LEN = NUM_FIELDS * (FIELD_BYTES + 1) + 1;
  localparam int unsigned FRAME_W   = FRAME_LEN * 8;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_SEND, S_ACK, S_DRAIN, S_NEXT, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [FRAME_W-1:0]  frame_q, frame_d, frame_c;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                stop_q, stop_d;
  logic                mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                tx_start_d;
  logic [7:0]          tx_data_d;
  logic                busy_d;
  logic                done_d;
  logic [15:0]         count_d;

  // Whole frame image built from the record; it is shifted out from the top byte.
  always_comb begin
    frame_c = '0;
    frame_c[FRAME_W-1 -: 8] = OPEN_BYTE;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      for (int j = 0; j < FIELD_BYTES; j++) begin
        frame_c[FRAME_W-1-8*(1+k*(FIELD_BYTES+1)+j) -: 8] =
          mem_rdata[REC_W-1-8*(k*FIELD_BYTES+j) -: 8];
      end
      frame_c[FRAME_W-1-8*(1+k*(FIELD_BYTES+1)+FIELD_BYTES) -: 8] =
        (k == NUM_FIELDS - 1) ? EOL_BYTE : SEP_BYTE;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    done_d     = 1'b0;
    count_d    = frame_count;

    if (state_q != S_IDLE && stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          last_d  = last_addr;
          addr_d  = '0;
          state_d = (last_addr == '0) ? S_FINISH : S_READ;
        end
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: begin
        frame_d = frame_c;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = frame_q[FRAME_W-1 -: 8];
          state_d    = S_ACK;
        end
      end
      S_ACK: if (tx_busy) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!tx_busy) begin
          if (idx_q != IDX_W'(FRAME_LEN - 1)) begin
            idx_d   = idx_q + IDX_W'(1);
            frame_d = {frame_q[FRAME_W-9:0], 8'h00};
            state_d = S_SEND;
          end else begin
            count_d = frame_count + 16'd1;
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (stop_q || stop) begin
          state_d = S_FINISH;
        end else if (({1'b0, addr_q} + (ADDR_W+1)'(1)) < {1'b0, last_q}) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_READ;
        end else if (continuous) begin
          addr_d  = '0;
          state_d = S_READ;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        stop_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    mem_en_d   = (state_d == S_READ);
    mem_addr_d = mem_en_d ? addr_d : mem_addr;
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      frame_q     <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      mem_en      <= mem_en_d;
      mem_addr    <= mem_addr_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      busy        <= busy_d;
      done        <= done_d;
      frame_count <= count_d;
    end
  end

endmodule

// File: tb/tb_report_frame_streamer.sv
// Bench for report_frame_streamer: BRAM and UART models around a default instance
// and a 2-field/2-byte instance, with a byte scoreboard fed from the bench's own memory image.
module tb_report_frame_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop, continuous, force_busy;
  logic [7:0]  last_addr;
  logic        mem_en, tx_start, tx_busy, busy, done;
  logic [7:0]  mem_addr, tx_data;
  logic [23:0] mem_rdata;
  logic [15:0] frame_count;

  logic        b_start, b_zero;
  logic [7:0]  b_last;
  logic        b_mem_en, b_tx_start, b_tx_busy, b_busy, b_done;
  logic [7:0]  b_mem_addr, b_tx_data;
  logic [31:0] b_mem_rdata;
  logic [15:0] b_frame_count;

  report_frame_streamer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .last_addr(last_addr), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy),
    .done(done), .frame_count(frame_count)
  );

  report_frame_streamer #(.NUM_FIELDS(2), .FIELD_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_zero), .continuous(b_zero),
    .last_addr(b_last), .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
    .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_busy(b_tx_busy), .busy(b_busy),
    .done(b_done), .frame_count(b_frame_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // BRAM and transmitter models (3 busy cycles per byte)
  logic [23:0] mem [256];
  int tx_cnt = 0;
  int b_cnt = 0;
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];
  always @(posedge clk) if (tx_start) tx_cnt <= 3; else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  assign tx_busy = (tx_cnt != 0) || force_busy;
  always @(posedge clk) if (b_mem_en) b_mem_rdata <= (b_mem_addr == 8'd0) ? 32'hA1B2C3D4 : 32'h0;
  always @(posedge clk) if (b_tx_start) b_cnt <= 3; else if (b_cnt > 0) b_cnt <= b_cnt - 1;
  assign b_tx_busy = (b_cnt != 0);

  // Scoreboard and pulse counters
  logic [7:0] exp_q[$];
  logic [7:0] b_got[$];
  int sent = 0;
  int done_cnt = 0;
  int b_done_cnt = 0;
  logic [7:0] held;
  bit held_vld = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      held_vld = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (b_done) b_done_cnt++;
      if (b_tx_start) b_got.push_back(b_tx_data);
      if (tx_start) begin
        sent++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tx_start got=%02h required=none at %0t", tx_data, $time);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        held = tx_data;
        held_vld = 1'b1;
      end else if (held_vld && tx_cnt > 0) begin
        check("tx_data_hold", 32'(tx_data), 32'(held));
      end
    end
  end

  task automatic push_frame(input int a);
    logic [23:0] r;
    r = mem[a];
    exp_q.push_back(8'h5B); exp_q.push_back(r[23:16]);
    exp_q.push_back(8'h5C); exp_q.push_back(r[15:8]);
    exp_q.push_back(8'h5C); exp_q.push_back(r[7:0]);
    exp_q.push_back(8'h0A);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, 32'(mem_en), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_frame_count"}, 32'(frame_count), 0);
  endtask

  task automatic wait_done(input int base, input int budget);
    int cyc = 0;
    while (done_cnt == base && cyc < budget) begin tick(); cyc++; end
    repeat (3) tick();
    check("done_once", 32'(done_cnt - base), 1);
  endtask

  task automatic wait_sent(input int target, input int budget);
    int cyc = 0;
    while (sent < target && cyc < budget) begin tick(); cyc++; end
    check("sent_reached", 32'(sent >= target), 1);
  endtask

  typedef struct {
    int last;
    bit cont;
    int stop_after;
    int frames;
  } vec_t;

  vec_t vecs[7];
  logic [15:0] exp_count = 16'd0;

  task automatic run_vec(input vec_t v);
    int base = done_cnt;
    int sbase = sent;
    int cyc = 0;
    bit stopped = 1'b0;
    for (int f = 0; f < v.frames; f++) push_frame(f % v.last);
    last_addr = 8'(v.last); continuous = v.cont; start = 1'b1;
    tick();
    start = 1'b0;
    while (done_cnt == base && cyc < v.frames * 60 + 100) begin
      if (v.stop_after > 0 && !stopped && (sent - sbase) >= v.stop_after) begin
        stop = 1'b1; stopped = 1'b1;
      end else begin
        stop = 1'b0;
      end
      tick();
      cyc++;
    end
    stop = 1'b0; continuous = 1'b0;
    repeat (3) tick();
    exp_count += 16'(v.frames);
    check("vec_done_once", 32'(done_cnt - base), 1);
    check("vec_frame_count", 32'(frame_count), 32'(exp_count));
    check("vec_bytes_sent", 32'(sent - sbase), 32'(7 * v.frames));
    check("vec_queue_empty", 32'(exp_q.size()), 0);
    check("vec_busy_low", 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] b_exp [7];
    int base, sbase;

    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; last_addr = 8'd0;
    force_busy = 1'b0; b_start = 1'b0; b_zero = 1'b0; b_last = 8'd1;
    for (int a = 0; a < 256; a++) mem[a] = 24'($urandom);
    mem[0] = 24'h112233;
    mem[1] = 24'h445566;
    vecs[0] = '{last: 2,   cont: 1'b0, stop_after: 0,  frames: 2};
    vecs[1] = '{last: 0,   cont: 1'b0, stop_after: 0,  frames: 0};
    vecs[2] = '{last: 3,   cont: 1'b1, stop_after: 30, frames: 5};
    vecs[3] = '{last: 1,   cont: 1'b0, stop_after: 0,  frames: 1};
    vecs[4] = '{last: 3,   cont: 1'b0, stop_after: 3,  frames: 1};
    vecs[5] = '{last: 3,   cont: 1'b0, stop_after: 0,  frames: 3};
    vecs[6] = '{last: 255, cont: 1'b0, stop_after: 0,  frames: 255};
    b_exp = '{8'h5B, 8'hA1, 8'hB2, 8'h5C, 8'hC3, 8'hD4, 8'h0A};

    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // start-to-tx_start latency with an idle transmitter
    push_frame(0);
    base = done_cnt;
    last_addr = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    check("lat_mem_en", 32'(mem_en), 1);
    check("lat_mem_addr", 32'(mem_addr), 0);
    check("lat_busy", 32'(busy), 1);
    check("lat_tx_start_c1", 32'(tx_start), 0);
    tick();
    check("lat_mem_en_once", 32'(mem_en), 0);
    check("lat_tx_start_c2", 32'(tx_start), 0);
    tick();
    check("lat_tx_start_c3", 32'(tx_start), 0);
    tick();
    check("lat_tx_start_c4", 32'(tx_start), 1);
    wait_done(base, 200);
    exp_count += 16'd1;
    check("lat_frame_count", 32'(frame_count), 32'(exp_count));

    // empty dump: done two cycles after start, nothing transmitted
    base = done_cnt; sbase = sent;
    last_addr = 8'd0; start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    check("empty_busy", 32'(busy), 1);
    check("empty_done_early", 32'(done), 0);
    tick();
    check("empty_done", 32'(done), 1);
    check("empty_busy_low", 32'(busy), 0);
    tick();
    check("empty_done_pulse", 32'(done), 0);
    check("empty_no_tx", 32'(sent - sbase), 0);

    // transmitter stuck busy: no tx_start until it frees up
    push_frame(0);
    base = done_cnt; sbase = sent;
    force_busy = 1'b1; last_addr = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    repeat (100) tick();
    check("stall_no_tx", 32'(sent - sbase), 0);
    check("stall_busy", 32'(busy), 1);
    force_busy = 1'b0;
    wait_done(base, 200);
    exp_count += 16'd1;
    check("stall_frame_count", 32'(frame_count), 32'(exp_count));

    // reset mid-byte after an ignored restart, then a fresh dump from address 0
    push_frame(0); push_frame(1);
    base = done_cnt; sbase = sent;
    last_addr = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    wait_sent(sbase + 3, 300);
    start = 1'b1;
    tick(); start = 1'b0;
    wait_sent(sbase + 10, 300);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    check_all_zero("abort");
    rst = 1'b0;
    exp_count = 16'd0;
    repeat (12) tick();
    check("abort_no_done", 32'(done_cnt - base), 0);
    check("abort_idle", 32'(busy), 0);
    push_frame(0); push_frame(1);
    base = done_cnt;
    last_addr = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    wait_done(base, 300);
    exp_count += 16'd2;
    check("restart_frame_count", 32'(frame_count), 32'(exp_count));
    check("restart_queue_empty", 32'(exp_q.size()), 0);

    // 2 fields of 2 bytes each
    base = b_done_cnt;
    b_start = 1'b1;
    tick(); b_start = 1'b0;
    for (int c = 0; c < 200 && b_done_cnt == base; c++) tick();
    check("w_done", 32'(b_done_cnt - base), 1);
    check("w_len", 32'(b_got.size()), 7);
    for (int i = 0; i < 7; i++)
      check("w_byte", (i < b_got.size()) ? 32'(b_got[i]) : 32'hFFFF_FFFF, 32'(b_exp[i]));
    check("w_frame_count", 32'(b_frame_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
